// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: entry payload, FSM state encoding, default depth.
package store_buffer_pkg;

    localparam int unsigned SB_DEPTH_DEFAULT = 4;
    localparam int unsigned SB_WADDR_W       = 30;
    localparam int unsigned SB_DATA_W        = 32;

    typedef struct packed {
        logic [SB_WADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0]  data;
    } sb_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        READ  = 2'd2
    } sb_state_t;

endpackage

// File: rtl/sb_fifo.sv
// Circular FIFO of buffered stores; exposes head, occupancy and the raw entry array.
module sb_fifo
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  sb_entry_t                   push_entry,
    input  logic                        pop,
    output sb_entry_t                   head,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count,
    output logic [$clog2(DEPTH)-1:0]    rd_ptr,
    output sb_entry_t [DEPTH-1:0]       entries
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [PW-1:0] wr_ptr;

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) entries[wr_ptr] <= push_entry;
    end

    assign head  = entries[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/store_buffer.sv
// Write buffer between CPU and data memory: queues stores, drains in order, serialises loads.
// Optional store-to-load forwarding is enabled by defining STORE_BUFFER_FWD_EN.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH      = SB_DEPTH_DEFAULT,
    parameter int unsigned MEM_ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    input  logic                  cpu_memwrite,
    input  logic                  cpu_memread,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_stall,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    sb_state_t              state, state_nxt;
    sb_entry_t              head;
    sb_entry_t [DEPTH-1:0]  entries;
    logic                   full, empty;
    logic [CW-1:0]          count;
    logic [PW-1:0]          rd_ptr;
    logic [29:0]            rd_waddr;
    logic                   is_load, is_store, load_hit, push, pop, read_done;
    logic                   fwd_hit;
    logic [31:0]            fwd_data;
    logic [31:0]            mem_byte_addr;
    logic                   unused_ok;

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry ('{addr: cpu_addr[31:2], data: cpu_wdata}),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .rd_ptr     (rd_ptr),
        .entries    (entries)
    );

`ifdef STORE_BUFFER_FWD_EN
    logic [PW-1:0] fwd_idx;

    // Walk from head to tail so the youngest matching store wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && (entries[fwd_idx].addr == cpu_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[fwd_idx].data;
            end
        end
    end

    assign unused_ok = ^cpu_addr[1:0];
`else
    assign fwd_hit   = 1'b0;
    assign fwd_data  = '0;
    assign unused_ok = ^{cpu_addr[1:0], entries, rd_ptr};
`endif

    assign is_load   = cpu_memread;
    assign is_store  = cpu_memwrite & ~cpu_memread;
    assign load_hit  = is_load & fwd_hit & (state != READ);
    assign pop       = (state == DRAIN) & mem_ready;
    assign push      = is_store & (~full | pop);
    assign read_done = (state == READ) & mem_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Load address is captured on entry to READ so the bus stays stable until mem_ready.
    always_ff @(posedge clk) begin
        if (rst)                                      rd_waddr <= '0;
        else if ((state == IDLE) && (state_nxt == READ)) rd_waddr <= cpu_addr[31:2];
    end

    always_comb begin
        state_nxt     = state;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        mem_byte_addr = '0;
        mem_wdata     = '0;
        cpu_rdata     = '0;
        cpu_stall     = 1'b0;

        case (state)
            IDLE: begin
                if (!empty)                    state_nxt = DRAIN;
                else if (is_load && !load_hit) state_nxt = READ;
            end
            DRAIN: begin
                mem_we        = 1'b1;
                mem_byte_addr = {head.addr, 2'b00};
                mem_wdata     = head.data;
                if (pop && (count == CW'(1)) && !push) state_nxt = IDLE;
            end
            READ: begin
                mem_re        = 1'b1;
                mem_byte_addr = {rd_waddr, 2'b00};
                if (mem_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (!rst) begin
            if (load_hit)       cpu_rdata = fwd_data;
            else if (read_done) cpu_rdata = mem_rdata;
            cpu_stall = (is_store && !push) || (is_load && !load_hit && !read_done);
        end
    end

    assign mem_addr = MEM_ADDR_W'(mem_byte_addr);

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered stores (power of two, >=2).
REQ-002 SHALL have parameter MEM_ADDR_W, default 32, meaning data-memory address width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cpu_addr  input  32  byte address from ALU result.
REQ-006 cpu_wdata  input  32  store data (register-file read port 2).
REQ-007 cpu_memwrite  input  1  store request this cycle.
REQ-008 cpu_memread  input  1  load request this cycle.
REQ-009 cpu_rdata  output  32  load data returned to writeback mux.
REQ-010 cpu_stall  output  1  combinational; CPU holds PC and suppresses register write while high.
REQ-011 mem_addr  output  MEM_ADDR_W  data-memory address.
REQ-012 mem_wdata  output  32  data-memory write data.
REQ-013 mem_we / mem_re  output  1 each  memory write / read strobe.
REQ-014 mem_rdata  input  32  memory read data; mem_ready  input  1  memory completes current access this cycle.

Function
REQ-015 SHALL hold up to DEPTH {word address = cpu_addr[31:2], data} entries in a circular FIFO; cpu_addr[1:0] ignored.
REQ-016 SHALL accept a store (push) on an edge where cpu_memwrite=1 and (count<DEPTH or a pop occurs that same edge); otherwise cpu_stall=1 and no push.
REQ-017 SHALL drain FIFO head in order: while count>0 and no load in service, mem_we=1 with mem_addr/mem_wdata = head, held stable until mem_ready=1; pop on that edge.
REQ-018 SHALL never assert mem_we and mem_re in the same cycle.
REQ-019 SHALL implement FSM IDLE, DRAIN, READ: IDLE->DRAIN when count>0; DRAIN->IDLE on pop leaving count=0; IDLE->READ on unforwarded load with count=0; READ->IDLE on mem_ready.
REQ-020 Unforwarded load with count>0 SHALL stall until FIFO empties, then mem_re=1 with mem_addr={cpu_addr[31:2],2'b00} until mem_ready; cpu_rdata=mem_rdata and cpu_stall=0 in the mem_ready cycle (minimum latency 1 cycle after empty).
REQ-021 Simultaneous cpu_memwrite and cpu_memread SHALL be treated as a load only (no push).
REQ-022 count SHALL be $clog2(DEPTH)+1 bits; pointers $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-023 cpu_rdata SHALL be 0 when no load completes that cycle.

Reset
REQ-024 On rst: count=0, pointers=0, FSM=IDLE, mem_we=0, mem_re=0, cpu_stall=0, cpu_rdata=0; buffered stores discarded.
REQ-025 rst mid-drain or mid-read SHALL abort the access in the same edge; mem_ready during rst ignored.

Configuration
REQ-026 With STORE_BUFFER_FWD_EN defined: load whose word address matches any valid entry SHALL return the youngest matching data combinationally, cpu_stall=0, no memory access, no drain wait.
REQ-027 Without STORE_BUFFER_FWD_EN: every load SHALL follow REQ-020; no address comparators synthesised.

Structure
REQ-028 Package store_buffer_pkg SHALL hold DEPTH default, sb_entry_t {word addr [29:0], data [31:0]}, and sb_state_t enum {IDLE, DRAIN, READ}.
REQ-029 FIFO storage and pointers SHALL be sub-module sb_fifo (push, pop, head, full, empty, count, entry array view for forwarding); FSM, stall, and forwarding in store_buffer.

Verification
REQ-030 Store 0x1234 to 0x10, mem_ready tied 1 -> next edge mem_we=1, mem_addr=0x10, mem_wdata=0x1234; count returns to 0 one edge later.
REQ-031 mem_ready=0, five back-to-back stores, DEPTH=4 -> stores 1-4 accepted, 5th sees cpu_stall=1 until first mem_ready pulse, then accepted in that edge.
REQ-032 FWD_EN, stores 0xA to 0x20 then 0xB to 0x20, mem_ready=0, load 0x22 -> cpu_rdata=0xB, cpu_stall=0 same cycle, mem_re=0.
REQ-033 No FWD_EN, two stores buffered, load 0x40, mem_ready=1 -> stall through 2 drain cycles, then mem_re=1, cpu_rdata=mem_rdata, stall drops.
REQ-034 rst asserted while DRAIN with 3 entries -> next cycle count=0, mem_we=0, IDLE; post-reset store behaves as REQ-030.
